// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer: fetch/execute phase, program counter and hardware return-address stack
module pc_stack_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0,
    localparam int SP_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              incPC,
    input  logic              loadPC,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] newaddr,
    output logic [ADDR_W-1:0] addr,
    output logic              phase,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] top,
    output logic              overflow,
    output logic              underflow
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] r_addr;
    logic              r_phase;
    logic [SP_W-1:0]   r_sp;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] r_stack [DEPTH];

    logic [ADDR_W-1:0] w_inc;
    logic [SP_W-1:0]   w_sp_m1;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_top;

    // Next sequential address, stack indices and occupancy flags
    always_comb begin
        w_inc    = r_addr + ADDR_W'(1);
        w_sp_m1  = r_sp - SP_W'(1);
        w_wr_idx = r_sp[IDX_W-1:0];
        w_rd_idx = w_sp_m1[IDX_W-1:0];
        w_empty  = (r_sp == '0);
        w_full   = (r_sp == SP_W'(DEPTH));
        w_top    = w_empty ? '0 : r_stack[w_rd_idx];
    end

    // Phase toggles every unstalled edge; commands act only on the execute-phase edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= ADDR_W'(RESET_ADDR);
            r_phase <= 1'b0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
        end else if (!stall) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                if (ret) begin
                    if (w_empty) begin
                        r_addr <= w_inc;
                        r_unf  <= 1'b1;
                    end else begin
                        r_addr <= w_top;
                        r_sp   <= w_sp_m1;
                    end
                end else if (call) begin
                    r_addr <= newaddr;
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_stack[w_wr_idx] <= w_inc;
                        r_sp              <= r_sp + SP_W'(1);
                    end
                end else if (loadPC) begin
                    r_addr <= newaddr;
                end else if (incPC) begin
                    r_addr <= w_inc;
                end
            end
        end
    end

    assign addr      = r_addr;
    assign phase     = r_phase;
    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign top       = w_top;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
endmodule

// File: tb/tb_pc_stack_sequencer.sv
// tb_pc_stack_sequencer: table-driven directed checks of the PC/phase/return-stack sequencer
module tb_pc_stack_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, incPC = 1'b0, loadPC = 1'b0, call = 1'b0, ret = 1'b0;
    logic [11:0] newaddr = '0;
    logic [11:0] addr, top;
    logic        phase, empty, full, overflow, underflow;
    logic [2:0]  sp;

    pc_stack_sequencer #(.ADDR_W(12), .DEPTH(4), .RESET_ADDR(0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .incPC(incPC), .loadPC(loadPC),
        .call(call), .ret(ret), .newaddr(newaddr), .addr(addr), .phase(phase),
        .sp(sp), .empty(empty), .full(full), .top(top),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, inc, ld, cl, rt;
        logic [11:0] na;
        logic [11:0] e_addr;
        logic        e_ph;
        logic [2:0]  e_sp;
        logic        e_ovf, e_unf;
        logic [11:0] e_top;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   row = 0;

    task automatic add(input logic rst, stl, inc, ld, cl, rt, input logic [11:0] na,
                       input logic [11:0] ea, input logic ep, input logic [2:0] es,
                       input logic eo, eu, input logic [11:0] et);
        vec_t v;
        v.rst = rst; v.stl = stl; v.inc = inc; v.ld = ld; v.cl = cl; v.rt = rt; v.na = na;
        v.e_addr = ea; v.e_ph = ep; v.e_sp = es; v.e_ovf = eo; v.e_unf = eu; v.e_top = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, stl, inc, ld, cl, rt, input logic [11:0] na);
        reset = rst; stall = stl; incPC = inc; loadPC = ld; call = cl; ret = rt; newaddr = na;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input logic [11:0] ea, input logic ep, input logic [2:0] es,
                             input logic eo, eu, input logic [11:0] et);
        check("addr", 32'(addr), 32'(ea));
        check("phase", 32'(phase), 32'(ep));
        check("sp", 32'(sp), 32'(es));
        check("empty", 32'(empty), 32'(es == 3'd0));
        check("full", 32'(full), 32'(es == 3'd4));
        check("top", 32'(top), 32'(et));
        check("overflow", 32'(overflow), 32'(eo));
        check("underflow", 32'(underflow), 32'(eu));
    endtask

    initial begin
        //  rst stl inc ld cl rt  na       addr   ph sp ovf unf top
        add(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 12'h000);
        // increment: address moves only on execute edges
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 1, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h002, 0, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h002, 1, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h003, 0, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h003, 1, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h004, 0, 0, 0, 0, 12'h000);
        // jump to all-ones, then wrap on increment
        add(0, 0, 0, 1, 0, 0, 12'hFFF, 12'h004, 1, 0, 0, 0, 12'h000);
        add(0, 0, 0, 1, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'hFFF, 1, 0, 0, 0, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 12'h000);
        // nested call/return from 0x010
        add(0, 0, 0, 1, 0, 0, 12'h010, 12'h000, 1, 0, 0, 0, 12'h000);
        add(0, 0, 0, 1, 0, 0, 12'h010, 12'h010, 0, 0, 0, 0, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h100, 12'h010, 1, 0, 0, 0, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h100, 12'h100, 0, 1, 0, 0, 12'h011);
        add(0, 0, 0, 0, 1, 0, 12'h200, 12'h100, 1, 1, 0, 0, 12'h011);
        add(0, 0, 0, 0, 1, 0, 12'h200, 12'h200, 0, 2, 0, 0, 12'h101);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h200, 1, 2, 0, 0, 12'h101);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h101, 0, 1, 0, 0, 12'h011);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h101, 1, 1, 0, 0, 12'h011);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h011, 0, 0, 0, 0, 12'h000);
        // five calls into a four-deep stack
        add(0, 0, 0, 0, 1, 0, 12'h300, 12'h011, 1, 0, 0, 0, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h300, 12'h300, 0, 1, 0, 0, 12'h012);
        add(0, 0, 0, 0, 1, 0, 12'h400, 12'h300, 1, 1, 0, 0, 12'h012);
        add(0, 0, 0, 0, 1, 0, 12'h400, 12'h400, 0, 2, 0, 0, 12'h301);
        add(0, 0, 0, 0, 1, 0, 12'h500, 12'h400, 1, 2, 0, 0, 12'h301);
        add(0, 0, 0, 0, 1, 0, 12'h500, 12'h500, 0, 3, 0, 0, 12'h401);
        add(0, 0, 0, 0, 1, 0, 12'h600, 12'h500, 1, 3, 0, 0, 12'h401);
        add(0, 0, 0, 0, 1, 0, 12'h600, 12'h600, 0, 4, 0, 0, 12'h501);
        add(0, 0, 0, 0, 1, 0, 12'h700, 12'h600, 1, 4, 0, 0, 12'h501);
        add(0, 0, 0, 0, 1, 0, 12'h700, 12'h700, 0, 4, 1, 0, 12'h501);
        // five returns: LIFO, then underflow on the empty stack
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h700, 1, 4, 1, 0, 12'h501);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h501, 0, 3, 1, 0, 12'h401);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h501, 1, 3, 1, 0, 12'h401);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h401, 0, 2, 1, 0, 12'h301);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h401, 1, 2, 1, 0, 12'h301);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h301, 0, 1, 1, 0, 12'h012);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h301, 1, 1, 1, 0, 12'h012);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h012, 0, 0, 1, 0, 12'h000);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h012, 1, 0, 1, 0, 12'h000);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h013, 0, 0, 1, 1, 12'h000);
        // priority: ret beats call and loadPC with one entry on the stack
        add(0, 0, 0, 0, 1, 0, 12'h050, 12'h013, 1, 0, 1, 1, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h050, 12'h050, 0, 1, 1, 1, 12'h014);
        add(0, 0, 1, 1, 1, 1, 12'h0AA, 12'h050, 1, 1, 1, 1, 12'h014);
        add(0, 0, 1, 1, 1, 1, 12'h0AA, 12'h014, 0, 0, 1, 1, 12'h000);
        // stall during execute phase freezes everything
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h014, 1, 0, 1, 1, 12'h000);
        add(0, 1, 1, 0, 0, 0, 12'h000, 12'h014, 1, 0, 1, 1, 12'h000);
        add(0, 1, 1, 0, 0, 0, 12'h000, 12'h014, 1, 0, 1, 1, 12'h000);
        add(0, 1, 1, 0, 0, 0, 12'h000, 12'h014, 1, 0, 1, 1, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h015, 0, 0, 1, 1, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h015, 1, 0, 1, 1, 12'h000);
        add(0, 0, 1, 0, 0, 0, 12'h000, 12'h016, 0, 0, 1, 1, 12'h000);
        // call from 0xFFF pushes a wrapped return address of 0x000
        add(0, 0, 0, 1, 0, 0, 12'hFFF, 12'h016, 1, 0, 1, 1, 12'h000);
        add(0, 0, 0, 1, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 1, 1, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h123, 12'hFFF, 1, 0, 1, 1, 12'h000);
        add(0, 0, 0, 0, 1, 0, 12'h123, 12'h123, 0, 1, 1, 1, 12'h000);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h123, 1, 1, 1, 1, 12'h000);
        add(0, 0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 1, 1, 12'h000);
        // no command: address holds across an execute edge
        add(0, 0, 0, 0, 0, 0, 12'h777, 12'h000, 1, 0, 1, 1, 12'h000);
        add(0, 0, 0, 0, 0, 0, 12'h777, 12'h000, 0, 0, 1, 1, 12'h000);

        foreach (vecs[k]) begin
            row = k;
            drive(vecs[k].rst, vecs[k].stl, vecs[k].inc, vecs[k].ld, vecs[k].cl, vecs[k].rt, vecs[k].na);
            check_all(vecs[k].e_addr, vecs[k].e_ph, vecs[k].e_sp, vecs[k].e_ovf, vecs[k].e_unf, vecs[k].e_top);
        end

        // reset mid-operation with three entries stacked and stall asserted
        row = 1000;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 12'h0A0 + 12'(k));
            drive(0, 0, 0, 0, 1, 0, 12'h0A0 + 12'(k));
        end
        check_all(12'h0A2, 0, 3, 1, 1, 12'h0A2);
        row = 1001;
        drive(1, 1, 1, 0, 1, 0, 12'h555);
        check_all(12'h000, 0, 0, 0, 0, 12'h000);
        row = 1002;
        drive(0, 0, 1, 0, 0, 0, 12'h000);
        check_all(12'h000, 1, 0, 0, 0, 12'h000);
        row = 1003;
        drive(0, 0, 1, 0, 0, 0, 12'h000);
        check_all(12'h001, 0, 0, 0, 0, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_stack_sequencer.md
# pc_stack_sequencer

Parametrised program-counter and phase sequencer for the nibble processor, superseding the fixed 12-bit PC plus separate Phase flip-flop. It generates the fetch/execute phase, holds the instruction address driving the program ROM, and adds a hardware return-address stack for call/return, a stall input and sticky stack-error flags. The block sits between the microcode decoder, which supplies the control strobes, and the program ROM address port.

## Interface
- ADDR_W, 12, address width in bits (≥ 2)
- DEPTH, 4, return-stack entries (≥ 1)
- RESET_ADDR, 0, address loaded on reset
- SP_W, $clog2(DEPTH+1), stack-pointer width (derived, not overridden)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  freeze phase, PC and stack
- incPC  in  1  advance address by 1
- loadPC  in  1  jump to newaddr
- call  in  1  push return address, jump to newaddr
- ret  in  1  pop return address into PC
- newaddr  in  ADDR_W  jump/call target
- addr  out  ADDR_W  current instruction address (to ROM)
- phase  out  1  0 = fetch, 1 = execute
- sp  out  SP_W  number of valid stack entries
- empty  out  1  sp == 0
- full  out  1  sp == DEPTH
- top  out  ADDR_W  entry at top of stack; 0 when empty
- overflow  out  1  sticky: call attempted while full
- underflow  out  1  sticky: ret attempted while empty

## Operation
- Reset (clk edge with reset=1): addr=RESET_ADDR, phase=0, sp=0, overflow=0, underflow=0, all stack entries cleared to 0; reset overrides stall and every command.
- Phase: toggles each edge when stall=0; holds when stall=1.
- Commands are sampled only on an edge where phase=1 and stall=0 ("active edge"); at all other edges they are ignored and addr/stack hold.
- Priority on an active edge, highest first: ret > call > loadPC > incPC; only the winner acts.
- ret, not empty: addr ← top; sp ← sp−1.
- ret, empty: addr ← addr+1; underflow ← 1; sp stays 0.
- call, not full: stack[sp] ← addr+1; sp ← sp+1; addr ← newaddr.
- call, full: addr ← newaddr; stack and sp unchanged (return address dropped); overflow ← 1.
- loadPC: addr ← newaddr.
- incPC: addr ← addr+1.
- No command asserted: addr holds.
- Arithmetic: addr+1 is modulo 2^ADDR_W; all-ones wraps to 0, both for incPC and for the pushed return address.
- overflow/underflow clear only on reset.
- empty, full and top are combinational from sp and the stack array.

## Timing
- All state changes occur on the rising edge of clk; no combinational path from command inputs to addr, phase or sp.
- Latency: one edge from an active edge to the new addr. The ROM sees the new address in the following fetch phase.
- stall asserted during an execute phase holds phase=1, so pending commands are re-sampled at the first edge after stall deasserts.
- Reset asserted mid-sequence, including during stall, takes effect at that edge. The first edge after reset release is a fetch edge (phase 0→1).
- Error flags rise on the same edge as the offending ret or call.

## Test plan
- Reset/increment: reset for one edge, then incPC=1 held for 8 edges → addr=0 and phase=0 after reset; addr steps 0,0,1,1,2,2,3,3 (changes only on execute edges); phase alternates 0/1.
- Jump and wrap: with ADDR_W=12, loadPC with newaddr=0xFFF on an active edge, then incPC → addr=0xFFF, then 0x000.
- Nested call/return: at addr=0x010, call newaddr=0x100; at 0x100, call 0x200; then two rets → sp goes 1, 2, 1, 0; addr goes 0x100, 0x200, 0x101, 0x011; top=0x101 while sp=2.
- Overflow/underflow: with DEPTH=4, perform 5 calls → sp=4, full=1, overflow=1, addr = fifth target. Then 5 rets → entries return in LIFO order; the 5th ret gives addr = previous+1 and underflow=1, with overflow still 1.
- Priority and stall: assert ret+call+loadPC together with sp=1 → only the pop occurs. Then hold stall=1 for 3 edges with incPC=1 → addr, phase and sp are frozen; after release, increment resumes on the next execute edge.
- Reset mid-operation: with sp=3, overflow=1, stall=1, assert reset for one edge → addr=RESET_ADDR, sp=0, empty=1, overflow=0, underflow=0, phase=0, top=0.
